// File: rtl/aemb_ifetch_queue_if.sv
// Instruction-fetch queue bundle: Wishbone-classic instruction bus plus the decode-side
// handshake. "master" is the fetch queue; "slave" is the bus/decode environment.
interface aemb_ifetch_queue_if #(
  parameter int IW = 32
);
  logic          iwb_stb_o;
  logic [IW-1:2] iwb_adr_o;
  logic          iwb_ack_i;
  logic [31:0]   iwb_dat_i;
  logic          ins_vld_o;
  logic [31:0]   ins_dat_o;
  logic [IW-1:2] ins_pc_o;
  logic          ins_rdy_i;
  logic          bra_i;
  logic [IW-1:2] bra_adr_i;

  modport master (
    output iwb_stb_o, iwb_adr_o, ins_vld_o, ins_dat_o, ins_pc_o,
    input  iwb_ack_i, iwb_dat_i, ins_rdy_i, bra_i, bra_adr_i
  );

  modport slave (
    input  iwb_stb_o, iwb_adr_o, ins_vld_o, ins_dat_o, ins_pc_o,
    output iwb_ack_i, iwb_dat_i, ins_rdy_i, bra_i, bra_adr_i
  );
endinterface

// File: rtl/aemb_ifetch_queue.sv
// AEMB instruction-fetch queue: single-outstanding Wishbone prefetch into a DEPTH-entry queue.
// Optional AEMB_IFQ_BYPASS_EN: an ack into an empty queue is presented to decode in the same cycle.
module aemb_ifetch_queue #(
  parameter int            IW        = 32,
  parameter int            DEPTH     = 4,
  parameter int            AW        = 2,
  parameter logic [IW-1:0] RESET_ADR = '0
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  aemb_ifetch_queue_if.master  ifq
);
  typedef logic [IW-1:2] wadr_t;
  typedef struct packed {
    logic [31:0] dat;
    wadr_t       pc;
  } ent_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  ent_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;
  logic          stb, stb_nxt;
  wadr_t         adr, adr_nxt;
  logic          discard, discard_nxt;
  wadr_t         tgt;

  logic ack, push, pop, byp_hit, take;
  ent_t head;

  assign ack  = stb & ifq.iwb_ack_i;
  assign head = mem[rd_ptr];

  always_comb begin
    byp_hit = 1'b0;
`ifdef AEMB_IFQ_BYPASS_EN
    byp_hit = (count == '0) && ack && !discard && !ifq.bra_i;
`endif
    take = byp_hit & ifq.ins_rdy_i;
    // a branch in the same cycle as the ack discards the word and wins over any pop
    push = ack & ~discard & ~ifq.bra_i & ~take;
    pop  = ifq.ins_rdy_i & (count != '0) & ~ifq.bra_i;

    if (ifq.bra_i) count_nxt = '0;
    else           count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    stb_nxt = stb;
    adr_nxt = adr;
    // strobe and address are frozen while a request waits for its ack
    if (!stb || ack) begin
      if (ifq.bra_i)           adr_nxt = ifq.bra_adr_i;
      else if (ack && discard) adr_nxt = tgt;
      else if (ack)            adr_nxt = adr + 1'b1;
      stb_nxt = (count_nxt < FULL);
    end

    discard_nxt = discard;
    if (ack)                    discard_nxt = 1'b0;
    else if (ifq.bra_i && stb)  discard_nxt = 1'b1;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      stb     <= 1'b0;
      adr     <= RESET_ADR[IW-1:2];
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      discard <= 1'b0;
      tgt     <= '0;
    end else begin
      stb     <= stb_nxt;
      adr     <= adr_nxt;
      count   <= count_nxt;
      discard <= discard_nxt;
      if (ifq.bra_i) begin
        tgt    <= ifq.bra_adr_i;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // storage needs no reset: entries are only visible while count covers them
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= '{dat: ifq.iwb_dat_i, pc: adr};
  end

  always_comb begin
    ifq.ins_vld_o = (count != '0);
    ifq.ins_dat_o = (count != '0) ? head.dat : '0;
    ifq.ins_pc_o  = (count != '0) ? head.pc  : '0;
    if (byp_hit) begin
      ifq.ins_vld_o = 1'b1;
      ifq.ins_dat_o = ifq.iwb_dat_i;
      ifq.ins_pc_o  = adr;
    end
  end

  assign ifq.iwb_stb_o = stb;
  assign ifq.iwb_adr_o = adr;
endmodule

// File: doc/aemb_ifetch_queue.md
Name: aemb_ifetch_queue

Overview:
- Parametrised instruction-fetch front end for the next-generation AEMB core; replaces the single-entry instruction buffer.
- Masters the Wishbone-classic instruction bus, prefetches sequential words into a DEPTH-entry queue, and presents them with their PC to the decode stage.
- Branches flush the queue and redirect fetch.
- Sits between the instruction bus and the core's decode/control logic.

Parameters:
- IW, 32, instruction address width; word address bits are [IW-1:2].
- DEPTH, 4, queue entries; power of two, 2..16.
- AW, 2, log2(DEPTH); pointer width.
- RESET_ADR, 0, byte address fetched first after reset; bits [1:0] ignored.

Ports:
- sys_clk_i  in  1  core clock; all state updates on the rising edge.
- sys_rst_i  in  1  reset, asynchronous, active-low.
- iwb_stb_o  out  1  instruction bus strobe (registered).
- iwb_adr_o  out  IW-2  instruction word address [IW-1:2] (registered).
- iwb_ack_i  in  1  instruction bus acknowledge.
- iwb_dat_i  in  32  instruction bus read data.
- ins_vld_o  out  1  head entry valid.
- ins_dat_o  out  32  head instruction word.
- ins_pc_o  out  IW-2  word address of the head instruction.
- ins_rdy_i  in  1  decode accepts the head this cycle (pop when ins_vld_o=1).
- bra_i  in  1  branch taken: flush and redirect.
- bra_adr_i  in  IW-2  branch target word address.

Behaviour:
- Reset (sys_rst_i=0, asynchronous):
  - iwb_stb_o=0, iwb_adr_o=RESET_ADR[IW-1:2].
  - ins_vld_o=0, ins_dat_o=0, ins_pc_o=0.
  - count=0, rd/wr pointers=0, discard flag=0.
- Reset mid-transfer abandons the bus cycle and drops it with no further action.
- First rising edge after deassertion: iwb_stb_o=1 at RESET_ADR.
- Issue rule:
  - Only one outstanding request (classic Wishbone).
  - A request is issued (iwb_stb_o=1) when count + inflight < DEPTH.
  - iwb_stb_o and iwb_adr_o are held stable until the cycle in which iwb_ack_i=1.
- Ack, not discarded:
  - Write {iwb_dat_i, iwb_adr_o} into the queue at wr pointer; count+1.
  - Fetch address increments by 1 word, wrapping modulo 2^(IW-2).
  - iwb_stb_o stays 1 next cycle only if space remains after accounting for that cycle's pop.
- Pop: ins_rdy_i=1 with ins_vld_o=1 advances the rd pointer; count-1. Pop while empty is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap at DEPTH.
- Full (count=DEPTH): no new strobe. An ack already in flight always has a reserved slot, so overflow is impossible.
- ins_vld_o = (count != 0). ins_dat_o/ins_pc_o = head entry; zero when empty.
- Latency from ack to ins_vld_o: 1 cycle.
- Branch (bra_i=1):
  - Count and pointers are cleared next cycle; ins_vld_o=0 next cycle.
  - Flush wins over a pop in the same cycle.
  - No request outstanding: iwb_adr_o<=bra_adr_i and iwb_stb_o<=1 next cycle.
  - Request outstanding with no ack this cycle: set the discard flag. Keep strobe/address until ack; discard the returned word. On the following edge, iwb_adr_o<=saved target, iwb_stb_o=1.
  - bra_i in the same cycle as iwb_ack_i: the acked word is discarded, no discard flag is set, and the next fetch goes to bra_adr_i.
  - A second bra_i while the discard flag is set overwrites the saved target (last branch wins).

Optional Feature:
- Macro: AEMB_IFQ_BYPASS_EN.
- Defined: when the queue is empty, iwb_ack_i=1, no discard and no bra_i, the word bypasses the queue combinationally.
  - ins_vld_o=1, ins_dat_o=iwb_dat_i, ins_pc_o=iwb_adr_o in the same cycle.
  - If ins_rdy_i=1 that cycle, the word is consumed and not written into the queue; otherwise it is written normally.
  - Latency 0.
- Undefined: no combinational path from iwb_* to ins_*; latency 1 as above.

Test Plan:
- Reset release, RESET_ADR=0x100, ack every cycle, ins_rdy_i=0:
  - Addresses 0x40..0x43 are fetched, then iwb_stb_o=0 with count=4.
  - ins_pc_o=0x40 holds the first word.
- Queue full, then ins_rdy_i=1 for one cycle:
  - Head advances to 0x41.
  - Exactly one new strobe to 0x44 follows; count returns to 4 after its ack.
- Branch while a request is outstanding (strobe at 0x45, ack 3 cycles later), bra_adr_i=0x200:
  - Strobe stays at 0x45 until ack and its data is discarded.
  - Next strobe goes to 0x200; the first valid ins_pc_o is 0x200.
- bra_i coincident with iwb_ack_i and ins_rdy_i:
  - Acked word is dropped, no pop is counted, ins_vld_o=0 next cycle.
  - Next fetch goes to the target.
- Address wrap with IW=8, fetch at word 0x3F: next fetch is word 0x00.
- AEMB_IFQ_BYPASS_EN defined, empty queue, ack with data 0xB0000010 and ins_rdy_i=1:
  - ins_vld_o=1 with that data in the same cycle; count stays 0.
- Same case without the macro: ins_vld_o rises one cycle later.
- Async reset asserted mid-ack with count=3:
  - All outputs return to reset values immediately.
  - Fetch restarts at RESET_ADR.
